// File: rtl/sseg_scan_nd_if.sv
// Conversion request/status bundle for sseg_scan_nd.
//   bin   : unsigned value to convert
//   load  : single-cycle convert request
//   sign  : show minus sign, sampled together with bin
//   busy  : conversion in progress
//   ovf   : last converted value did not fit the display
interface sseg_scan_nd_if #(parameter int BIN_W = 27);
    logic [BIN_W-1:0] bin;
    logic             load;
    logic             sign;
    logic             busy;
    logic             ovf;

    modport master (output bin, load, sign, input  busy, ovf);
    modport slave  (input  bin, load, sign, output busy, ovf);
endinterface

// File: rtl/sseg_scan_nd.sv
// N-digit multiplexed common-anode seven-segment driver.
// A sequential double-dabble engine converts host.bin to BCD (BIN_W cycles),
// the result is committed atomically, and the digits are scanned one per
// prescaler tick with leading-zero blanking, floating sign, overflow dashes
// and one optional decimal point.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   host       : bin/load/sign in, busy/ovf out (sseg_scan_nd_if.slave)
//   valid      : 0 shows dashes on every digit (live)
//   dp_en/dp_sel : decimal point enable and digit index, 0 = rightmost (live)
//   blank_lz   : blank leading zeros (live)
//   ssegs      : active-low {a,b,c,d,e,f,g,dp}, registered
//   disp_en    : active-low one-hot digit anodes, registered
module sseg_scan_nd #(
    parameter int N_DIG = 8,
    parameter int BIN_W = 27,
    parameter int DIV_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    sseg_scan_nd_if.slave     host,
    input  logic              valid,
    input  logic              dp_en,
    input  logic [2:0]        dp_sel,
    input  logic              blank_lz,
    output logic [7:0]        ssegs,
    output logic [N_DIG-1:0]  disp_en
);
    localparam int WB = 4*N_DIG + 4;           // working BCD incl. guard digit
    localparam int IW = $clog2(N_DIG);
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state, state_nx;
    logic                 last;
    logic [BIN_W-1:0]     val_q;
    logic                 sign_cap;
    logic [WB-1:0]        work, adj, shifted;
    logic [CW-1:0]        cnt;
    logic                 lost;                // a 1 fell off the top of work
    logic [4*N_DIG-1:0]   disp;
    logic                 sign_f;
    logic                 ovf_q;
    logic [DIV_W-1:0]     presc;
    logic [IW-1:0]        idx;
    logic [7:0]           seg_nx;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0: s = 8'h03;  4'd1: s = 8'h9F;  4'd2: s = 8'h25;
            4'd3: s = 8'h0D;  4'd4: s = 8'h99;  4'd5: s = 8'h49;
            4'd6: s = 8'h41;  4'd7: s = 8'h1F;  4'd8: s = 8'h01;
            4'd9: s = 8'h09;  default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // add-3 on every nibble >= 5, then shift in the next value bit (MSB first)
    always_comb begin
        adj = work;
        for (int i = 0; i < N_DIG + 1; i++)
            if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        shifted = {adj[WB-2:0], val_q[BIN_W-1]};
    end

    always_comb begin
        state_nx = state;
        last     = 1'b0;
        case (state)
            IDLE:  if (host.load) state_nx = SHIFT;
            SHIFT: if (cnt == CW'(BIN_W - 1)) begin
                       state_nx = IDLE;
                       last     = 1'b1;
                   end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            val_q    <= '0;
            sign_cap <= 1'b0;
            work     <= '0;
            cnt      <= '0;
            lost     <= 1'b0;
            disp     <= '0;
            sign_f   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (host.load) begin
                    val_q    <= host.bin;
                    sign_cap <= host.sign;
                    work     <= '0;
                    cnt      <= '0;
                    lost     <= 1'b0;
                end
                SHIFT: begin
                    work  <= shifted;
                    val_q <= {val_q[BIN_W-2:0], 1'b0};
                    cnt   <= cnt + CW'(1);
                    lost  <= lost | adj[WB-1];
                    // commit digits, sign and overflow together so the
                    // display never shows a half-updated value
                    if (last) begin
                        disp   <= shifted[4*N_DIG-1:0];
                        sign_f <= sign_cap;
                        ovf_q  <= (shifted[WB-1:WB-4] != 4'd0) | lost | adj[WB-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign host.busy = (state == SHIFT);
    assign host.ovf  = ovf_q;

    // digit composition for the current scan position
    always_comb begin
        int         m, k;
        logic       all_dash;
        logic [7:0] code;
        m = 0;
        for (int i = 0; i < N_DIG; i++)
            if (disp[4*i +: 4] != 4'd0) m = i;
        k = int'(idx);
        // a sign with no free digit to its left cannot be shown
        all_dash = ovf_q | (sign_f & (m == N_DIG - 1));
        if (!valid || all_dash)  code = 8'hFD;
        else if (k > m) begin
            if (blank_lz) code = (sign_f && k == m + 1)     ? 8'hFD : 8'hFF;
            else          code = (sign_f && k == N_DIG - 1) ? 8'hFD : seg7(4'd0);
        end else          code = seg7(disp[4*k +: 4]);
        seg_nx = {code[7:1], ~(valid & dp_en & (int'(dp_sel) == k))};
    end

    // scan: outputs are registered from the same index, so segments and
    // anodes always change together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc   <= '0;
            idx     <= '0;
            ssegs   <= 8'hFF;
            disp_en <= '1;
        end else begin
            presc <= presc + DIV_W'(1);
            if (&presc) idx <= (idx == IW'(N_DIG - 1)) ? '0 : idx + IW'(1);
            ssegs   <= seg_nx;
            disp_en <= ~(N_DIG'(1) << idx);
        end
    end
endmodule

// File: tb/tb_sseg_scan_nd.sv
module tb_sseg_scan_nd;
    localparam int BW = 27;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sseg_scan_nd_if #(.BIN_W(BW)) h1 ();
    sseg_scan_nd_if #(.BIN_W(8))  h2 ();

    logic       valid, dp_en, blank_lz;
    logic [2:0] dp_sel;
    logic [7:0] ssegs, ssegs2;
    logic [7:0] disp_en;
    logic [5:0] disp_en2;

    sseg_scan_nd #(.N_DIG(8), .BIN_W(BW), .DIV_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .host(h1), .valid(valid), .dp_en(dp_en),
        .dp_sel(dp_sel), .blank_lz(blank_lz), .ssegs(ssegs), .disp_en(disp_en));

    sseg_scan_nd #(.N_DIG(6), .BIN_W(8), .DIV_W(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .host(h2), .valid(1'b1), .dp_en(1'b1),
        .dp_sel(3'd2), .blank_lz(1'b1), .ssegs(ssegs2), .disp_en(disp_en2));

    typedef struct {
        logic [7:0][7:0] codes;
        bit              ov;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0, done_cnt = 0;
    logic [7:0] SEG [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                             8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference: decimal digits by division, display rules applied directly
    function automatic logic [7:0][7:0] model(input longint v, input bit s,
                                              input bit blz, output bit ov);
        int d[8];
        longint t = v;
        int m = 0;
        logic [7:0][7:0] r;
        for (int k = 0; k < 8; k++) begin d[k] = int'(t % 10); t = t / 10; end
        ov = (v > 99_999_999);
        for (int k = 0; k < 8; k++) if (d[k] != 0) m = k;
        for (int k = 0; k < 8; k++) begin
            if (ov || (s && m == 7))  r[k] = 8'hFD;
            else if (k <= m)          r[k] = SEG[d[k]];
            else if (blz)             r[k] = (s && k == m + 1) ? 8'hFD : 8'hFF;
            else                      r[k] = (s && k == 7) ? 8'hFD : SEG[0];
        end
        return r;
    endfunction

    // sample one full scan frame of the 8-digit DUT
    task automatic capture(output logic [7:0][7:0] codes, output bit bad);
        codes = '0;
        bad   = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if ($countones(~disp_en) == 1) begin
                for (int i = 0; i < 8; i++) if (!disp_en[i]) codes[i] = ssegs;
            end else bad = 1'b1;
        end
    endtask

    task automatic chk_frame(input string nm, input logic [7:0][7:0] exp);
        logic [7:0][7:0] got;
        bit bad;
        capture(got, bad);
        chk({nm, "_anodes_bad"}, 64'(bad), 64'd0);
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s_dig%0d", nm, k), 64'(got[k]), 64'(exp[k]));
    endtask

    // monitor: a completed conversion is a busy falling edge out of reset
    initial begin
        bit   prev = 1'b0;
        int   run = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                prev = 1'b0;
                run  = 0;
            end else begin
                if (h1.busy) run++;
                if (prev && !h1.busy) begin
                    if (q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
                    else begin
                        e = q.pop_front();
                        chk("busy_len", 64'(run), 64'(BW));
                        chk("ovf", 64'(h1.ovf), 64'(e.ov));
                        @(negedge clk);
                        chk_frame("conv", e.codes);
                    end
                    run = 0;
                    done_cnt++;
                end
                prev = h1.busy;
            end
        end
    end

    task automatic wait_done(input int start);
        for (int i = 0; i < 300 && done_cnt == start; i++) @(negedge clk);
        if (done_cnt == start) chk("conv_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_load(input longint v, input bit s, input bit blz);
        exp_t e;
        bit   ov;
        int   start = done_cnt;
        @(negedge clk);
        blank_lz = blz;
        e.codes  = model(v, s, blz, ov);
        e.ov     = ov;
        q.push_back(e);
        h1.bin  = BW'(v);
        h1.sign = s;
        h1.load = 1'b1;
        @(negedge clk);
        h1.load = 1'b0;
        wait_done(start);
    endtask

    initial begin
        bit dummy;
        int start, r;
        longint v;
        valid = 1'b1; dp_en = 1'b0; dp_sel = 3'd0; blank_lz = 1'b1;
        h1.bin = '0; h1.load = 1'b0; h1.sign = 1'b0;
        h2.bin = '0; h2.load = 1'b0; h2.sign = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", 64'(h1.busy), 64'd0);
        chk("rst_ovf", 64'(h1.ovf), 64'd0);
        chk("rst_disp_en", 64'(disp_en), 64'hFF);
        @(negedge clk);
        chk_frame("rst", model(0, 0, 1, dummy));

        do_load(1234, 0, 1);
        do_load(100_000_000, 0, 1);
        do_load(99_999_999, 0, 1);
        do_load(42, 1, 1);
        do_load(12_345_678, 1, 1);
        do_load(0, 1, 0);
        do_load(134_217_727, 0, 0);
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: v = $urandom_range(0, 99);
                1: v = $urandom_range(0, 99_999);
                2: v = $urandom_range(0, 99_999_999);
                default: v = $urandom_range(100_000_000, 134_217_727);
            endcase
            do_load(v, 1'($urandom), 1'($urandom));
        end

        // second load during a conversion is dropped
        start = done_cnt;
        begin
            exp_t e;
            bit ov;
            @(negedge clk);
            blank_lz = 1'b1;
            e.codes = model(555, 0, 1, ov);
            e.ov = ov;
            q.push_back(e);
            h1.bin = 27'd555; h1.sign = 1'b0; h1.load = 1'b1;
            @(negedge clk); h1.load = 1'b0;
            @(negedge clk); h1.bin = 27'd777; h1.load = 1'b1;
            @(negedge clk); h1.load = 1'b0;
        end
        wait_done(start);
        repeat (60) @(negedge clk);
        chk("no_second_result", 64'(done_cnt), 64'(start + 1));

        // reset mid-conversion aborts without a visible partial result
        h1.bin = 27'd888; h1.load = 1'b1;
        @(negedge clk); h1.load = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 64'(h1.busy), 64'd0);
        chk("abort_ovf", 64'(h1.ovf), 64'd0);
        repeat (30) @(negedge clk);
        chk_frame("abort", model(0, 0, 1, dummy));

        // valid=0: dashes everywhere, decimal point suppressed
        valid = 1'b0; dp_en = 1'b1; dp_sel = 3'd0;
        @(negedge clk);
        chk_frame("invalid", {8{8'hFD}});
        valid = 1'b1;
        // decimal point on digit 3 of the zero display
        dp_sel = 3'd3;
        @(negedge clk);
        begin
            logic [7:0][7:0] e;
            e = model(0, 0, 1, dummy);
            e[3] = 8'hFE;
            chk_frame("dp3", e);
        end
        dp_en = 1'b0;

        // 6-digit scan walk, wrap and decimal point alignment
        begin
            int prev_i = -1, steps = 0, wraps = 0, badpat = 0, badstep = 0, dpbad = 0;
            int cur;
            logic [5:0][7:0] codes6 = '0;
            repeat (20 * 4 + 8) begin
                @(negedge clk);
                if ($countones(~disp_en2) != 1) badpat++;
                else begin
                    cur = 0;
                    for (int i = 0; i < 6; i++) if (!disp_en2[i]) cur = i;
                    codes6[cur] = ssegs2;
                    if (ssegs2[0] != disp_en2[2]) dpbad++;
                    if (prev_i >= 0 && cur != prev_i) begin
                        steps++;
                        if (cur != (prev_i + 1) % 6) badstep++;
                        if (prev_i == 5 && cur == 0) wraps++;
                    end
                    prev_i = cur;
                end
            end
            chk("scan6_badpattern", 64'(badpat), 64'd0);
            chk("scan6_badstep", 64'(badstep), 64'd0);
            chk("scan6_enough_ticks", 64'(steps >= 20), 64'd1);
            chk("scan6_wrap", 64'(wraps >= 3), 64'd1);
            chk("scan6_dp_align", 64'(dpbad), 64'd0);
            chk("scan6_dig0", 64'(codes6[0]), 64'h03);
            chk("scan6_dig2", 64'(codes6[2]), 64'hFE);
            chk("scan6_dig5", 64'(codes6[5]), 64'hFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sseg_scan_nd.md
Name: sseg_scan_nd

Overview:
- Parameterised N-digit multiplexed seven-segment driver. Successor to the fixed 4-digit display driver.
- Converts a BIN_W-bit unsigned value to BCD with a sequential shift-add-3 (double-dabble) engine, then scans N_DIG common-anode digits.
- Supports leading-zero blanking, a floating minus sign, overflow indication and a decimal point.
- Sits between datapath counters and the board display pins.

Parameters:
- N_DIG, 8: number of digits scanned (2..8; need not be a power of two).
- BIN_W, 27: input value width.
- DIV_W, 14: refresh prescaler width; scan advances once every 2^DIV_W clk cycles.

Ports:
- clk  in  1  system clock (100 MHz board clock).
- rst_n  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low.
- bin  in  BIN_W  unsigned value to display.
- load  in  1  single-cycle request to convert bin.
- sign  in  1  show minus sign; sampled with bin at load.
- valid  in  1  0 forces all digits to dash; live, not sampled.
- dp_en  in  1  enable one decimal point; live.
- dp_sel  in  3  digit index carrying the dp (0 = rightmost); live.
- blank_lz  in  1  1 blanks leading zeros; live.
- busy  out  1  conversion in progress.
- ovf  out  1  last converted value did not fit.
- ssegs  out  8  active-low {a,b,c,d,e,f,g,dp}, registered.
- disp_en  out  N_DIG  active-low digit anodes, one-hot-low, registered.

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - busy=0, ovf=0, BCD display register=0, sign flag=0.
  - Prescaler=0, scan index=0, bit counter=0.
  - disp_en=all ones, ssegs=8'hFF.
  - Reset wins over a simultaneous load.
  - Reset during a conversion aborts it; no partial result becomes visible.
- Conversion FSM, states IDLE and SHIFT:
  - IDLE, load=1: capture bin and sign, clear the working BCD (4*N_DIG+4 bits, including a guard digit), set busy=1, go to SHIFT.
  - SHIFT, each cycle: add 3 to every working nibble >=5, then shift left one bit, bringing in the MSB of the captured value first.
  - SHIFT runs exactly BIN_W cycles, then returns to IDLE.
  - On the cycle busy falls, update atomically: display register <= low N_DIG digits, sign flag <= captured sign, ovf <= (guard digit != 0 or any bit shifted out != 0).
  - Total latency: load at cycle t gives busy=1 for cycles t+1..t+BIN_W and new digits visible from t+BIN_W+1.
  - load while busy=1 is ignored; no queueing.
- Digit composition for scan position k (0 = rightmost):
  - valid=0: dash (8'hFD); dp forced off.
  - ovf=1: dash on every digit.
  - Otherwise, let m = index of the most significant nonzero digit (m=0 when the value is 0).
  - k>m and blank_lz=1: blank (8'hFF), except k=m+1 with sign flag set shows dash.
  - k>m and blank_lz=0: digit '0'; sign dash goes on k=N_DIG-1.
  - Sign set with m=N_DIG-1 (no room for the dash): treat as overflow, all dashes.
  - Digit 0 is never blanked.
- Segment codes: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, dash=FD, blank=FF.
- Decimal point: bit0 = ~dp_en when k==dp_sel, else 1. dp_sel >= N_DIG means no dp is shown.
- Scan:
  - Prescaler counts every clk. Tick when the prescaler is all ones.
  - On a tick, scan index increments, wrapping N_DIG-1 -> 0 explicitly.
  - ssegs and disp_en are registered from the current scan index. They change one clk after the index changes and are never both stale and mismatched.
  - disp_en[k]=0 only for the scanned k.
- Arithmetic: unsigned only. For the defaults, max representable value is 99_999_999; 27-bit inputs above it set ovf.

Test Plan:
- Reset: hold rst_n=0 for 3 clks, release -> busy=0, ovf=0, disp_en=8'hFF until first scan update. With blank_lz=1, digit0=03 and all others FF.
- N_DIG=8, BIN_W=27, load bin=1234, blank_lz=1 -> busy high exactly 27 cycles. Digits 3..0 = 9F,25,0D,99; digits 7..4 = FF; ovf=0.
- load bin=100_000_000 -> ovf=1, all 8 digits FD. Then load bin=99_999_999 -> all digits 09, ovf=0.
- load bin=42, sign=1, blank_lz=1 -> digit2=FD, digit1=99, digit0=25, others FF. With sign=1, bin=12_345_678 -> all FD.
- N_DIG=6, DIV_W=2: observe 20 ticks -> disp_en walks 111110 .. 011111 and wraps to 111110, never showing an invalid pattern. dp_en=1, dp_sel=2 -> ssegs bit0=0 only while disp_en[2]=0.
- load 555, then load 777 two cycles later (ignored), then rst_n=0 mid-conversion -> second load has no effect. After reset the display register is 0 and busy=0.
